// File: rtl/exc_seq_ctrl_if.sv
// Exception sequencer bus: boundary requests and PSR context in, PSR-bank strobes and PC redirect out.
// Latency: none (signal bundle only).
// Backpressure: none; the sequencer holds the core with stall instead of handshaking.
//
// Ports (slave = sequencer view):
//   in : instr_done, irq, fiq, und_req, svc_req, exc_ret, cpsr, pc_cur, pc_next, lr_in
//   out: Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR, lr_we, lr_data,
//        pc_load, pc_load_addr, stall, exc_err
interface exc_seq_if;
    logic        instr_done;
    logic        irq;
    logic        fiq;
    logic        und_req;
    logic        svc_req;
    logic        exc_ret;
    logic [31:0] cpsr;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic [31:0] lr_in;

    logic [2:0]  Change_M;
    logic        W_SPSR_s;
    logic        Write_SPSR;
    logic [2:0]  W_CPSR_s;
    logic        Write_CPSR;
    logic        lr_we;
    logic [31:0] lr_data;
    logic        pc_load;
    logic [31:0] pc_load_addr;
    logic        stall;
    logic        exc_err;

    modport master (
        output instr_done, irq, fiq, und_req, svc_req, exc_ret,
        output cpsr, pc_cur, pc_next, lr_in,
        input  Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR,
        input  lr_we, lr_data, pc_load, pc_load_addr, stall, exc_err
    );

    modport slave (
        input  instr_done, irq, fiq, und_req, svc_req, exc_ret,
        input  cpsr, pc_cur, pc_next, lr_in,
        output Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR,
        output lr_we, lr_data, pc_load, pc_load_addr, stall, exc_err
    );
endinterface

// File: rtl/exc_seq_ctrl.sv
// Exception entry/return sequencer driving the CPSR/SPSR bank strobes and the PC redirect.
// Latency: entry boundary -> pc_load in 3 cycles (SAVE, SWITCH, VEC); return 2 cycles (RETPC, RESTORE).
// Backpressure: holds stall high for the whole sequence; requests are only sampled in IDLE at instr_done.
//
// Ports: clk (posedge; PSR bank captures on negedge), rst (async, active-low),
//        bus (exc_seq_if.slave: boundary requests/context in, PSR strobes and PC redirect out).
module exc_seq_ctrl #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    exc_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SAVE, S_SWITCH, S_VEC, S_RETPC, S_RESTORE
    } state_t;

    typedef enum logic [1:0] {
        TGT_FIQ, TGT_IRQ, TGT_SVC, TGT_UND
    } tgt_t;

    // Bank select for Change_M
    function automatic logic [2:0] mode_sel(input tgt_t t);
        case (t)
            TGT_FIQ: mode_sel = 3'd1;
            TGT_IRQ: mode_sel = 3'd2;
            TGT_SVC: mode_sel = 3'd3;
            default: mode_sel = 3'd4;
        endcase
    endfunction

    // New-CPSR source select for W_CPSR_s (0 is reserved for restore-from-SPSR)
    function automatic logic [2:0] cpsr_sel(input tgt_t t);
        case (t)
            TGT_FIQ: cpsr_sel = 3'd3;
            TGT_IRQ: cpsr_sel = 3'd2;
            TGT_SVC: cpsr_sel = 3'd4;
            default: cpsr_sel = 3'd5;
        endcase
    endfunction

    function automatic logic [31:0] vec_off(input tgt_t t);
        case (t)
            TGT_FIQ: vec_off = 32'h1C;
            TGT_IRQ: vec_off = 32'h18;
            TGT_SVC: vec_off = 32'h08;
            default: vec_off = 32'h04;
        endcase
    endfunction

    state_t      state_q, state_d;
    tgt_t        tgt_q, tgt_d;
    logic [31:0] lr_q, lr_d;

    logic [2:0]  change_m_q, change_m_d;
    logic        w_spsr_s_q, w_spsr_s_d;
    logic        write_spsr_q, write_spsr_d;
    logic [2:0]  w_cpsr_s_q, w_cpsr_s_d;
    logic        write_cpsr_q, write_cpsr_d;
    logic        lr_we_q, lr_we_d;
    logic [31:0] lr_data_q, lr_data_d;
    logic        pc_load_q, pc_load_d;
    logic [31:0] pc_load_addr_q, pc_load_addr_d;
    logic        stall_q, stall_d;
    logic        exc_err_q, exc_err_d;

    logic fiq_win, irq_win, sync_req, usr_sys;

    always_comb begin
        fiq_win  = bus.fiq & ~bus.cpsr[6];
        irq_win  = bus.irq & ~bus.cpsr[7];
        sync_req = bus.und_req | bus.svc_req;
        usr_sys  = (bus.cpsr[4:0] == 5'b10000) || (bus.cpsr[4:0] == 5'b11111);
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        lr_d      = lr_q;
        exc_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_done) begin
                    if (fiq_win || irq_win) begin
                        tgt_d   = fiq_win ? TGT_FIQ : TGT_IRQ;
                        // A co-pending sync request is abandoned: return to the
                        // faulting instruction so it re-executes.
                        lr_d    = (sync_req ? bus.pc_cur : bus.pc_next) + 32'd4;
                        state_d = S_SAVE;
                    end else if (sync_req) begin
                        tgt_d   = bus.und_req ? TGT_UND : TGT_SVC;
                        lr_d    = bus.pc_next;
                        state_d = S_SAVE;
                    end else if (bus.exc_ret) begin
                        if (usr_sys) begin
                            exc_err_d = 1'b1;
                        end else begin
                            // Banked LR captured now, while still in the exception mode.
                            lr_d    = bus.lr_in;
                            state_d = S_RETPC;
                        end
                    end
                end
            end
            S_SAVE:    state_d = S_SWITCH;
            S_SWITCH:  state_d = S_VEC;
            S_VEC:     state_d = S_IDLE;
            S_RETPC:   state_d = S_RESTORE;
            S_RESTORE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        change_m_d     = 3'd0;
        w_spsr_s_d     = 1'b0;
        write_spsr_d   = 1'b0;
        w_cpsr_s_d     = 3'd0;
        write_cpsr_d   = 1'b0;
        lr_we_d        = 1'b0;
        lr_data_d      = 32'd0;
        pc_load_d      = 1'b0;
        pc_load_addr_d = 32'd0;
        stall_d        = 1'b0;
        case (state_d)
            S_SAVE: begin
                change_m_d   = mode_sel(tgt_d);
                w_spsr_s_d   = 1'b1;
                write_spsr_d = 1'b1;
                lr_we_d      = 1'b1;
                lr_data_d    = lr_d;
                stall_d      = 1'b1;
            end
            S_SWITCH: begin
                change_m_d   = mode_sel(tgt_d);
                w_cpsr_s_d   = cpsr_sel(tgt_d);
                write_cpsr_d = 1'b1;
                stall_d      = 1'b1;
            end
            S_VEC: begin
                pc_load_d      = 1'b1;
                pc_load_addr_d = VEC_BASE + vec_off(tgt_d);
                stall_d        = 1'b1;
            end
            S_RETPC: begin
                pc_load_d      = 1'b1;
                pc_load_addr_d = lr_d;
                stall_d        = 1'b1;
            end
            S_RESTORE: begin
                write_cpsr_d = 1'b1;
                stall_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            tgt_q          <= TGT_FIQ;
            lr_q           <= 32'd0;
            change_m_q     <= 3'd0;
            w_spsr_s_q     <= 1'b0;
            write_spsr_q   <= 1'b0;
            w_cpsr_s_q     <= 3'd0;
            write_cpsr_q   <= 1'b0;
            lr_we_q        <= 1'b0;
            lr_data_q      <= 32'd0;
            pc_load_q      <= 1'b0;
            pc_load_addr_q <= 32'd0;
            stall_q        <= 1'b0;
            exc_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tgt_q          <= tgt_d;
            lr_q           <= lr_d;
            change_m_q     <= change_m_d;
            w_spsr_s_q     <= w_spsr_s_d;
            write_spsr_q   <= write_spsr_d;
            w_cpsr_s_q     <= w_cpsr_s_d;
            write_cpsr_q   <= write_cpsr_d;
            lr_we_q        <= lr_we_d;
            lr_data_q      <= lr_data_d;
            pc_load_q      <= pc_load_d;
            pc_load_addr_q <= pc_load_addr_d;
            stall_q        <= stall_d;
            exc_err_q      <= exc_err_d;
        end
    end

    assign bus.Change_M     = change_m_q;
    assign bus.W_SPSR_s     = w_spsr_s_q;
    assign bus.Write_SPSR   = write_spsr_q;
    assign bus.W_CPSR_s     = w_cpsr_s_q;
    assign bus.Write_CPSR   = write_cpsr_q;
    assign bus.lr_we        = lr_we_q;
    assign bus.lr_data      = lr_data_q;
    assign bus.pc_load      = pc_load_q;
    assign bus.pc_load_addr = pc_load_addr_q;
    assign bus.stall        = stall_q;
    assign bus.exc_err      = exc_err_q;
endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Bench for exc_seq_ctrl: directed scenarios followed by randomized boundaries,
// all compared each cycle against a queue-of-expected-cycles reference model.
module tb_exc_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exc_seq_if bus ();

    exc_seq_ctrl #(.VEC_BASE(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [2:0]  change_m;
        logic        w_spsr_s;
        logic        write_spsr;
        logic [2:0]  w_cpsr_s;
        logic        write_cpsr;
        logic        lr_we;
        logic [31:0] lr_data;
        logic        pc_load;
        logic [31:0] pc_load_addr;
        logic        stall;
        logic        exc_err;
    } obs_t;

    // idle: the design will evaluate the boundary inputs on the next edge
    typedef struct packed {
        logic idle;
        obs_t o;
    } rec_t;

    // Exception kinds: 0 fiq, 1 irq, 2 und, 3 svc
    localparam logic [2:0]  MODE_SEL [4] = '{3'd1, 3'd2, 3'd4, 3'd3};
    localparam logic [2:0]  CPSR_SEL [4] = '{3'd3, 3'd2, 3'd5, 3'd4};
    localparam logic [31:0] VEC_ADDR [4] = '{32'h1C, 32'h18, 32'h04, 32'h08};

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    rec_t exp_cur;

    function automatic obs_t sample();
        obs_t o;
        o.change_m     = bus.Change_M;
        o.w_spsr_s     = bus.W_SPSR_s;
        o.write_spsr   = bus.Write_SPSR;
        o.w_cpsr_s     = bus.W_CPSR_s;
        o.write_cpsr   = bus.Write_CPSR;
        o.lr_we        = bus.lr_we;
        o.lr_data      = bus.lr_data;
        o.pc_load      = bus.pc_load;
        o.pc_load_addr = bus.pc_load_addr;
        o.stall        = bus.stall;
        o.exc_err      = bus.exc_err;
        return o;
    endfunction

    function automatic rec_t idle_rec();
        rec_t r;
        r      = '0;
        r.idle = 1'b1;
        return r;
    endfunction

    // Reference model: decides what the design does with the inputs now on
    // the bus and queues the cycles it should produce.
    task automatic model_step();
        rec_t        r;
        int          k;
        logic [31:0] link;
        k = -1;
        if (exp_cur.idle && bus.instr_done) begin
            if (bus.fiq && !bus.cpsr[6])      k = 0;
            else if (bus.irq && !bus.cpsr[7]) k = 1;
            else if (bus.und_req)             k = 2;
            else if (bus.svc_req)             k = 3;
            if (k >= 0) begin
                if (k < 2)
                    link = ((bus.und_req || bus.svc_req) ? bus.pc_cur : bus.pc_next) + 32'd4;
                else
                    link = bus.pc_next;
                r = '0;
                r.o.change_m = MODE_SEL[k]; r.o.w_spsr_s = 1'b1; r.o.write_spsr = 1'b1;
                r.o.lr_we = 1'b1; r.o.lr_data = link; r.o.stall = 1'b1;
                exp_q.push_back(r);
                r = '0;
                r.o.change_m = MODE_SEL[k]; r.o.w_cpsr_s = CPSR_SEL[k];
                r.o.write_cpsr = 1'b1; r.o.stall = 1'b1;
                exp_q.push_back(r);
                r = '0;
                r.o.pc_load = 1'b1; r.o.pc_load_addr = VEC_ADDR[k]; r.o.stall = 1'b1;
                exp_q.push_back(r);
            end else if (bus.exc_ret) begin
                if (bus.cpsr[4:0] == 5'b10000 || bus.cpsr[4:0] == 5'b11111) begin
                    r = idle_rec();
                    r.o.exc_err = 1'b1;
                    exp_q.push_back(r);
                end else begin
                    r = '0;
                    r.o.pc_load = 1'b1; r.o.pc_load_addr = bus.lr_in; r.o.stall = 1'b1;
                    exp_q.push_back(r);
                    r = '0;
                    r.o.write_cpsr = 1'b1; r.o.stall = 1'b1;
                    exp_q.push_back(r);
                end
            end
        end
        if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
        else                  exp_cur = idle_rec();
    endtask

    task automatic check_out(input string tag);
        obs_t obs;
        obs = sample();
        checks++;
        assert (obs === exp_cur.o) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_cur.o);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Inputs are set at a negedge; the design samples them on the next posedge
    // and the result is checked at the negedge after that.
    task automatic tick(input string tag);
        model_step();
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic clr();
        bus.instr_done = 1'b0;
        bus.irq        = 1'b0;
        bus.fiq        = 1'b0;
        bus.und_req    = 1'b0;
        bus.svc_req    = 1'b0;
        bus.exc_ret    = 1'b0;
    endtask

    initial begin
        logic [4:0] mode;
        clr();
        bus.cpsr    = 32'h0000_0010;
        bus.pc_cur  = 32'd0;
        bus.pc_next = 32'd4;
        bus.lr_in   = 32'd0;
        exp_cur     = idle_rec();
        rst         = 1'b0;

        // Reset state
        #1;
        check_out("reset");
        @(negedge clk);
        check_out("reset_hold");
        rst = 1'b1;
        tick("idle_0");
        tick("idle_1");

        // IRQ entry
        bus.cpsr = 32'h0000_0010; bus.irq = 1'b1; bus.instr_done = 1'b1;
        bus.pc_cur = 32'hFC; bus.pc_next = 32'h100;
        tick("irq_save");
        check_val("irq_save_mode", bus.Change_M, 32'd2);
        check_val("irq_save_lr", bus.lr_data, 32'h104);
        check_val("irq_save_wspsr", bus.Write_SPSR, 32'd1);
        clr();
        tick("irq_switch");
        check_val("irq_switch_sel", bus.W_CPSR_s, 32'd2);
        check_val("irq_switch_wcpsr", bus.Write_CPSR, 32'd1);
        tick("irq_vec");
        check_val("irq_vec_addr", bus.pc_load_addr, 32'h18);
        tick("irq_idle");
        check_val("irq_idle_stall", bus.stall, 32'd0);

        // I masked: FIQ wins
        bus.cpsr = 32'h0000_0090; bus.irq = 1'b1; bus.fiq = 1'b1; bus.instr_done = 1'b1;
        tick("fiq_save");
        check_val("fiq_save_mode", bus.Change_M, 32'd1);
        clr();
        tick("fiq_switch");
        check_val("fiq_switch_sel", bus.W_CPSR_s, 32'd3);
        tick("fiq_vec");
        check_val("fiq_vec_addr", bus.pc_load_addr, 32'h1C);
        tick("fiq_idle");

        // Both masked: no entry
        bus.cpsr = 32'h0000_00D0; bus.irq = 1'b1; bus.fiq = 1'b1; bus.instr_done = 1'b1;
        tick("masked");
        check_val("masked_stall", bus.stall, 32'd0);
        clr();
        tick("masked_idle");

        // Interrupt over undefined
        bus.cpsr = 32'h0000_0010; bus.fiq = 1'b1; bus.und_req = 1'b1; bus.instr_done = 1'b1;
        bus.pc_cur = 32'h200; bus.pc_next = 32'h300;
        tick("fiq_und_save");
        check_val("fiq_und_lr", bus.lr_data, 32'h204);
        check_val("fiq_und_mode", bus.Change_M, 32'd1);
        clr();
        tick("fiq_und_switch");
        tick("fiq_und_vec");
        tick("fiq_und_idle");

        // Return from IRQ mode
        bus.cpsr = 32'h0000_0012; bus.exc_ret = 1'b1; bus.instr_done = 1'b1; bus.lr_in = 32'h104;
        tick("ret_pc");
        check_val("ret_pc_addr", bus.pc_load_addr, 32'h104);
        check_val("ret_pc_load", bus.pc_load, 32'd1);
        clr();
        tick("ret_restore");
        check_val("ret_restore_wcpsr", bus.Write_CPSR, 32'd1);
        check_val("ret_restore_sel", bus.W_CPSR_s, 32'd0);
        check_val("ret_restore_mode", bus.Change_M, 32'd0);
        tick("ret_idle");

        // Return attempted in USR mode
        bus.cpsr = 32'h0000_0010; bus.exc_ret = 1'b1; bus.instr_done = 1'b1;
        tick("ret_usr");
        check_val("ret_usr_err", bus.exc_err, 32'd1);
        check_val("ret_usr_wcpsr", bus.Write_CPSR, 32'd0);
        clr();
        tick("ret_usr_after");
        check_val("ret_usr_err_pulse", bus.exc_err, 32'd0);

        // Reset during SWITCH
        bus.cpsr = 32'h0000_0013; bus.irq = 1'b1; bus.instr_done = 1'b1; bus.pc_next = 32'h400;
        tick("rst_mid_save");
        clr();
        tick("rst_mid_switch");
        rst = 1'b0;
        #1;
        exp_q.delete();
        exp_cur = idle_rec();
        check_out("rst_mid");
        @(negedge clk);
        check_out("rst_mid_hold");
        rst = 1'b1;

        // SVC after reset
        bus.cpsr = 32'h0000_0010; bus.svc_req = 1'b1; bus.instr_done = 1'b1;
        bus.pc_cur = 32'h4FC; bus.pc_next = 32'h500;
        tick("svc_save");
        check_val("svc_save_lr", bus.lr_data, 32'h500);
        clr();
        tick("svc_switch");
        tick("svc_vec");
        check_val("svc_vec_addr", bus.pc_load_addr, 32'h08);
        tick("svc_idle");

        // Randomized boundaries
        for (int i = 0; i < 600; i++) begin
            bus.instr_done = ($urandom_range(0, 1) == 1);
            bus.irq        = ($urandom_range(0, 3) == 0);
            bus.fiq        = ($urandom_range(0, 5) == 0);
            bus.und_req    = ($urandom_range(0, 7) == 0);
            bus.svc_req    = ($urandom_range(0, 7) == 0);
            bus.exc_ret    = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       mode = 5'b10000;
                1:       mode = 5'b10001;
                2:       mode = 5'b10010;
                3:       mode = 5'b10011;
                4:       mode = 5'b11011;
                default: mode = 5'b11111;
            endcase
            bus.cpsr    = {$urandom_range(0, 255), 16'h0, $urandom_range(0, 1) == 1,
                           $urandom_range(0, 1) == 1, 1'b0, mode};
            bus.pc_cur  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            bus.pc_next = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : bus.pc_cur + 32'd4;
            bus.lr_in   = $urandom;
            tick("rand");
        end

        clr();
        tick("final_idle");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exc_seq_ctrl.md
Name: exc_seq_ctrl

Overview:
Exception entry/return sequencer for the CPSR/SPSR bank. It samples interrupt and synchronous exception requests at instruction boundaries and stalls the core. It then drives the PSR bank's select and write strobes (Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR) over a fixed multi-cycle sequence, and finally redirects the PC to the vector or to the saved link address. It sits between the control unit and the CPSR/SPSR register block.

Parameters:
VEC_BASE, 32'h0000_0000, base of the exception vector table.

Ports:
clk  in  1  clock; PSR bank captures on negedge, this block on posedge.
rst  in  1  asynchronous, active-low reset.
instr_done  in  1  current instruction completes this cycle (boundary).
irq  in  1  level IRQ request.
fiq  in  1  level FIQ request.
und_req  in  1  undefined instruction; valid only with instr_done.
svc_req  in  1  SWI/SVC; valid only with instr_done.
exc_ret  in  1  exception-return instruction (MOVS/SUBS pc,lr); valid only with instr_done.
cpsr  in  32  current CPSR (bit7 I, bit6 F, [4:0] mode).
pc_cur  in  32  address of the instruction at the boundary.
pc_next  in  32  sequential next PC.
lr_in  in  32  banked LR of the current mode.
Change_M  out  3  0 = current mode, 1 fiq, 2 irq, 3 svc, 4 und.
W_SPSR_s  out  1  1 = SPSR source is CPSR.
Write_SPSR  out  1  SPSR write strobe.
W_CPSR_s  out  3  0 = restore from SPSR, 2 irq, 3 fiq, 4 svc, 5 und.
Write_CPSR  out  1  CPSR write strobe.
lr_we  out  1  write lr_data into the target-mode banked LR.
lr_data  out  32  link value.
pc_load  out  1  force PC to pc_load_addr.
pc_load_addr  out  32  vector or return address.
stall  out  1  freeze fetch/decode.
exc_err  out  1  one-cycle pulse: exc_ret issued in USR/SYS mode (ignored).

Behaviour:
- States: IDLE, SAVE, SWITCH, VEC, RETPC, RESTORE. Outputs are Moore-decoded from the state and the latched target register tgt (2 bits) and lr_q (32 bits).
- Reset (rst=0, async): state=IDLE, tgt=0, lr_q=0. All outputs 0, including Change_M and W_CPSR_s.
- IDLE: all strobes 0, stall=0. Requests are evaluated only when instr_done=1.
- Priority at the boundary:
  - fiq & ~cpsr[6]
  - then irq & ~cpsr[7]
  - then und_req
  - then svc_req
  - then exc_ret.
- A winning exception latches tgt and lr_q, then moves to SAVE.
- lr_q values:
  - irq/fiq: pc_next+4.
  - irq/fiq while und_req or svc_req is also set: pc_cur+4. The faulting instruction then re-executes after return, and the synchronous request is dropped.
  - und/svc: pc_next.
- exc_ret with no exception pending:
  - cpsr[4:0] is 10000 or 11111: exc_err=1 for one cycle, state stays IDLE.
  - otherwise: go to RETPC.
- exc_ret arriving together with any exception is dropped.
- SAVE (1 cycle): Change_M=tgt code, W_SPSR_s=1, Write_SPSR=1, lr_we=1, lr_data=lr_q, stall=1. Next state SWITCH.
- SWITCH (1 cycle): Change_M=tgt code, W_CPSR_s=target code (fiq 3, irq 2, svc 4, und 5), Write_CPSR=1, stall=1. Next state VEC.
- VEC (1 cycle): pc_load=1, stall=1. Next state IDLE.
  - pc_load_addr = VEC_BASE + 0x04 (und), 0x08 (svc), 0x18 (irq), 0x1C (fiq).
- Entry latency: boundary to pc_load is 3 cycles. The next boundary is evaluated no earlier than the cycle after VEC.
- RETPC (1 cycle): pc_load=1, pc_load_addr=lr_in sampled while still in exception mode, stall=1. Next state RESTORE.
- RESTORE (1 cycle): Change_M=0, W_CPSR_s=0, Write_CPSR=1, stall=1. Next state IDLE.
- irq/fiq deasserted mid-sequence: the sequence completes unchanged (tgt is latched).
- Requests outside IDLE, or without instr_done: ignored.
- Reset mid-sequence: immediate IDLE, all strobes 0. A partial PSR write is the PSR bank's concern.
- Only one of Write_SPSR or Write_CPSR is asserted in any cycle.
- Register widths are 32-bit; +4 wraps modulo 2^32.

Test Plan:
- Reset then idle: rst=0 → all outputs 0, stall=0. Release with no requests → remain IDLE.
- IRQ entry: cpsr=0x0000_0010, irq=1, instr_done=1, pc_next=0x100.
  - SAVE: Change_M=2, W_SPSR_s=1, Write_SPSR=1, lr_data=0x104.
  - SWITCH: W_CPSR_s=2, Write_CPSR=1.
  - VEC: pc_load_addr=0x18. Then IDLE.
- Masking and priority:
  - cpsr I=1, irq=1, fiq=1 → FIQ taken (Change_M=1, W_CPSR_s=3, vector 0x1C).
  - cpsr F=1 and I=1 → no entry.
- Interrupt over undefined: fiq=1, und_req=1, pc_cur=0x200 → FIQ entry with lr_data=0x204. und_req dropped.
- Return: cpsr mode 10010, exc_ret=1, lr_in=0x104 → RETPC pc_load_addr=0x104, then RESTORE with W_CPSR_s=0, Change_M=0, Write_CPSR=1. In USR mode → exc_err pulse, no strobes.
- Reset mid-operation: assert rst=0 during SWITCH → outputs 0 in the same cycle, IDLE after release. A subsequent svc_req gives vector 0x08, lr_data=pc_next.
